approx_mul_pipe: RTL and testbench

APPROX_MUL_PIPE -- requirements
Module: approx_mul_pipe

---
 rtl/approx_mul_pipe.sv | 130 +++++++++++++
 tb/tb_approx_mul_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - two-stage pipelined unsigned multiplier with exact/truncated modes
//
// Optional feature macro: APPROX_MUL_BIAS_COMP_EN
//   When defined (and TRUNC > 0), approximate products get the constant
//   2^(TRUNC-1) added, which centres the truncation error.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block accepts operands this cycle (== advance)
//   in_a       unsigned multiplicand, WIDTH bits
//   in_b       unsigned multiplier, WIDTH bits
//   in_mode    0 = exact product, 1 = approximate product
//   out_valid  product available
//   out_ready  consumer accepts product this cycle
//   out_p      product, 2*WIDTH bits
//   out_mode   mode bit of the transaction on out_p
//   txn_count  completed output handshakes, wraps at 16 bits
module approx_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_mode,
  output logic [15:0]        txn_count
);

  localparam int PW = 2 * WIDTH;

`ifdef APPROX_MUL_BIAS_COMP_EN
  localparam logic [PW-1:0] BIAS =
    (TRUNC > 0) ? ({{(PW-1){1'b0}}, 1'b1} << ((TRUNC > 0) ? (TRUNC - 1) : 0)) : '0;
`else
  localparam logic [PW-1:0] BIAS = '0;
`endif

  // The whole pipeline moves as a unit: it advances whenever the output
  // register is empty or being drained, so bubbles are never collapsed.
  logic advance;
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;

  // Column keep-mask for approximate mode: bit k of a shifted row is the sum
  // of partial-product bits with i+j == k, so dropping columns < TRUNC is a
  // plain AND with this mask.
  logic [PW-1:0] col_mask;
  for (genvar k = 0; k < PW; k++) begin : g_mask
    assign col_mask[k] = (k >= TRUNC) ? 1'b1 : 1'b0;
  end

  // Partial-product rows formed from the incoming operands.
  logic [PW-1:0] pp_rows [WIDTH];
  logic [PW-1:0] row_mask;

  always_comb begin
    row_mask = in_mode ? col_mask : '1;
    for (int j = 0; j < WIDTH; j++) begin
      pp_rows[j] = ({{WIDTH{1'b0}}, in_a & {WIDTH{in_b[j]}}} << j) & row_mask;
    end
  end

  // Stage 1: mode and masked partial-product rows.
  logic          s1_valid;
  logic          s1_mode;
  logic [PW-1:0] s1_rows [WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      for (int j = 0; j < WIDTH; j++) begin
        s1_rows[j] <= '0;
      end
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_rows <= pp_rows;
      end
    end
  end

  // Row summation feeding stage 2; bias only applies to approximate results.
  logic [PW-1:0] sum_p;

  always_comb begin
    sum_p = '0;
    for (int j = 0; j < WIDTH; j++) begin
      sum_p = sum_p + s1_rows[j];
    end
    if (s1_mode) begin
      sum_p = sum_p + BIAS;
    end
  end

  // Stage 2: output register. Data only reloads for real transactions, so
  // out_p/out_mode stay put through bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_mode  <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_p    <= sum_p;
        out_mode <= s1_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= 16'd0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb/tb_approx_mul_pipe.sv - self-checking bench for approx_mul_pipe
module tb_approx_mul_pipe;

  localparam int W = 8;
  localparam int T = 4;
  localparam int P = 2 * W;

`ifdef APPROX_MUL_BIAS_COMP_EN
  localparam int EXP_FF_APX = 64984;
  localparam int EXP_35_APX = 8;
  localparam int EXP_16_APX = 264;
`else
  localparam int EXP_FF_APX = 64976;
  localparam int EXP_35_APX = 0;
  localparam int EXP_16_APX = 256;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [P-1:0] out_p;
  logic         out_mode;
  logic [15:0]  txn_count;

  approx_mul_pipe #(.WIDTH(W), .TRUNC(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_mode  (out_mode),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: exact product, or sum of a[i]&b[j] weighted 2^(i+j) for i+j >= T.
  function automatic logic [P-1:0] ref_mul(input int a, input int b, input bit mode);
    int s;
    if (!mode) return P'(a * b);
    s = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (i + j >= T && ((a >> i) & 1) == 1 && ((b >> j) & 1) == 1)
          s += (1 << (i + j));
`ifdef APPROX_MUL_BIAS_COMP_EN
    if (T > 0) s += (1 << (T - 1));
`endif
    return P'(s);
  endfunction

  typedef struct {
    logic [P-1:0] p;
    logic         m;
  } exp_t;

  exp_t         q[$];
  logic [15:0]  exp_cnt = 16'd0;
  bit           held_v  = 1'b0;
  logic [P-1:0] held_p;
  logic         held_m;

  always @(negedge rst_n) begin
    q.delete();
    exp_cnt = 16'd0;
    held_v  = 1'b0;
  end

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      exp_cnt = 16'd0;
      held_v  = 1'b0;
    end else begin
      check("txn_count", {16'd0, txn_count}, {16'd0, exp_cnt});
      check("in_ready_rule", {31'd0, in_ready}, {31'd0, (out_ready || !out_valid)});
      if (held_v) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_p", {16'd0, out_p}, {16'd0, held_p});
        check("hold_mode", {31'd0, out_mode}, {31'd0, held_m});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("out_p", {16'd0, out_p}, {16'd0, e.p});
          check("out_mode", {31'd0, out_mode}, {31'd0, e.m});
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.p = ref_mul(int'(in_a), int'(in_b), in_mode);
        e.m = in_mode;
        q.push_back(e);
      end
      held_v = out_valid && !out_ready;
      held_p = out_p;
      held_m = out_mode;
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_txn", {16'd0, txn_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_p", {16'd0, out_p}, 32'd0);
    check("rst_out_mode", {31'd0, out_mode}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One transaction with out_ready high: exact 2-cycle latency.
  task automatic run_one(input string tag, input int a, input int b, input bit mode, input int exp);
    in_valid  = 1'b1;
    in_a      = W'(a);
    in_b      = W'(b);
    in_mode   = mode;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_lat2"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_p"}, {16'd0, out_p}, 32'(exp));
    check({tag, "_mode"}, {31'd0, out_mode}, {31'd0, mode});
    @(posedge clk); #1;
  endtask

  initial begin
    int           idx;
    int           delivered;
    int           stall_left;
    bit           first;
    bit           pending;
    logic [P-1:0] stall_p;
    int           guard;

    in_a    = '0;
    in_b    = '0;
    in_mode = 1'b0;
    do_reset();

    run_one("ff_exact", 255, 255, 1'b0, 65025);
    run_one("ff_apx",   255, 255, 1'b1, EXP_FF_APX);
    run_one("35_apx",   3,   5,   1'b1, EXP_35_APX);
    run_one("35_exact", 3,   5,   1'b0, 15);
    run_one("16_exact", 16,  16,  1'b0, 256);
    run_one("16_apx",   16,  16,  1'b1, EXP_16_APX);

    // Randomized traffic with random backpressure; producer holds stalled requests.
    pending = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = pick();
        in_b     = pick();
        in_mode  = 1'($urandom_range(0, 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      pending = in_valid && !in_ready;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 32'(q.size()), 32'd0);

    // Back-to-back stream of 4 with a 3-cycle stall after the first result.
    do_reset();
    idx = 0; delivered = 0; stall_left = 0; first = 1'b0; stall_p = '0;
    for (int cyc = 0; cyc < 40 && delivered < 4; cyc++) begin
      @(posedge clk); #1;
      in_valid = (idx < 4);
      in_a     = W'(idx * 37 + 11);
      in_b     = W'(idx * 19 + 200);
      in_mode  = idx[0];
      if (out_valid && !first) begin
        first      = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        if (stall_left < 3) check("stall_p_stable", {16'd0, out_p}, {16'd0, stall_p});
        stall_p = out_p;
        stall_left--;
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) delivered++;
    end
    check("stall_delivered", 32'(delivered), 32'd4);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_txn", {16'd0, txn_count}, 32'd4);

    // Reset pulse with two transactions in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'd7;
    in_b      = 8'd9;
    in_mode   = 1'b0;
    @(posedge clk); #1;
    in_a = 8'd200;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_txn", {16'd0, txn_count}, 32'd0);
    #1 rst_n = 1'b1;
    run_one("after_rst", 200, 3, 1'b0, 600);
    repeat (3) begin
      @(negedge clk);
      check("no_stale", {31'd0, out_valid}, 32'd0);
    end

    // 65537 handshakes: counter wraps to 1.
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      in_a    = W'($urandom);
      in_b    = W'($urandom);
      in_mode = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("wrap_txn", {16'd0, txn_count}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
